// File: rtl/sdp_ram_pkg.sv
// sdp_ram_pkg: shared types and helpers for the sdp_ram_param family.
package sdp_ram_pkg;

    // Widest word the lane-merge helper handles; callers zero-extend into it.
    localparam int MAX_W     = 1024;
    localparam int MAX_LANES = 128;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } st_e;

    // Number of byte-enable lanes in a word.
    function automatic int lane_cnt(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

    // Lane-merged word: lanes with be set come from new_w, the rest from old_w.
    function automatic logic [MAX_W-1:0] be_merge(
        input logic [MAX_W-1:0]     old_w,
        input logic [MAX_W-1:0]     new_w,
        input logic [MAX_LANES-1:0] be,
        input int                   byte_w
    );
        logic [MAX_W-1:0] lane_ones;
        logic [MAX_W-1:0] mask;
        lane_ones = ~({MAX_W{1'b1}} << byte_w);
        mask      = '0;
        for (int l = 0; l < MAX_LANES; l++)
            if (be[l]) mask = mask | (lane_ones << (l * byte_w));
        return (old_w & ~mask) | (new_w & mask);
    endfunction

endpackage

// File: rtl/sdp_ram_rd_pipe.sv
// sdp_ram_rd_pipe: read data/valid pipeline, 1 stage (OUT_REG=0) or 2 stages.
// Data stages only load on a valid beat, so the output holds between reads.
module sdp_ram_rd_pipe
    import sdp_ram_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int OUT_REG = 1
) (
    input  logic              clock0,
    input  logic              aclr0,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data
);
    localparam int STAGES = (OUT_REG != 0) ? 2 : 1;

    logic [STAGES:1]             vld_q;
    logic [STAGES:1][DATA_W-1:0] dat_q;
    logic [STAGES:0]             vld_pipe;
    logic [STAGES:0][DATA_W-1:0] dat_pipe;

    assign vld_pipe = {vld_q, in_vld};
    assign dat_pipe = {dat_q, in_data};

    // Shift valid every cycle; move data only behind a valid beat.
    always_ff @(posedge clock0 or posedge aclr0) begin
        if (aclr0) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            for (int s = 1; s <= STAGES; s++) begin
                vld_q[s] <= vld_pipe[s-1];
                if (vld_pipe[s-1]) dat_q[s] <= dat_pipe[s-1];
            end
        end
    end

    assign out_vld  = vld_pipe[STAGES];
    assign out_data = dat_pipe[STAGES];

endmodule

// File: rtl/sdp_ram_param.sv
// sdp_ram_param: simple dual-port RAM with byte-enable writes, 1/2-cycle reads
// and selectable read-during-write. Define SDP_RAM_INIT_CLEAR_EN to build the
// post-reset clear engine; without it the RAM is ready right after reset.
module sdp_ram_param
    import sdp_ram_pkg::*;
#(
    parameter  int DATA_W    = 32,
    parameter  int BYTE_W    = 8,
    parameter  int ADDR_W    = 8,
    parameter  int DEPTH     = 256,
    parameter  int OUT_REG   = 1,
    parameter  int RDW_NEW   = 1,
    localparam int NUM_LANES = lane_cnt(DATA_W, BYTE_W)
) (
    input  logic                 clock0,
    input  logic                 aclr0,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic [NUM_LANES-1:0] wr_be,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 rd_valid,
    output logic                 init_busy
);
    logic [DATA_W-1:0] mem [DEPTH];

    st_e               state;
    logic              ready, wr_in_rng, rd_in_rng, wr_go, rd_go;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd, wr_merged, rd_word;

`ifdef SDP_RAM_INIT_CLEAR_EN
    st_e               state_nxt;
    logic [ADDR_W-1:0] clr_addr;

    // State and clear-address registers; reset always restarts the clear at word 0.
    always_ff @(posedge clock0 or posedge aclr0) begin
        if (aclr0) begin
            state    <= ST_INIT;
            clr_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) clr_addr <= clr_addr + 1'b1;
        end
    end

    // Leave INIT once the last word is being cleared; READY is terminal.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:  if (clr_addr == ADDR_W'(DEPTH - 1)) state_nxt = ST_READY;
            default:  state_nxt = ST_READY;
        endcase
    end
`else
    assign state = ST_READY;
`endif

    assign ready     = (state == ST_READY);
    assign init_busy = ~ready;
    assign wr_in_rng = ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH));
    assign rd_in_rng = ({1'b0, rd_addr} < (ADDR_W+1)'(DEPTH));
    assign wr_go     = ready & wr_en & wr_in_rng;
    assign rd_go     = ready & rd_en;

    // Stored word with enabled lanes replaced; shared by write and bypass.
    assign wr_merged = DATA_W'(be_merge(MAX_W'(mem[wr_addr]), MAX_W'(wr_data),
                                        MAX_LANES'(wr_be), BYTE_W));

    // Write-port mux: the clear engine owns the port while it runs.
    always_comb begin
        mem_we = wr_go;
        mem_wa = wr_addr;
        mem_wd = wr_merged;
`ifdef SDP_RAM_INIT_CLEAR_EN
        if (state == ST_INIT) begin
            mem_we = 1'b1;
            mem_wa = clr_addr;
            mem_wd = '0;
        end
`endif
    end

    // Storage array; no reset so contents survive aclr0.
    always_ff @(posedge clock0) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    // Read word: 0 out of range, merged new data on a collision when RDW_NEW.
    always_comb begin
        rd_word = '0;
        if (rd_in_rng) begin
            rd_word = mem[rd_addr];
            if (RDW_NEW != 0 && wr_go && (wr_addr == rd_addr)) rd_word = wr_merged;
        end
    end

    sdp_ram_rd_pipe #(
        .DATA_W  (DATA_W),
        .OUT_REG (OUT_REG)
    ) u_rd_pipe (
        .clock0   (clock0),
        .aclr0    (aclr0),
        .in_vld   (rd_go),
        .in_data  (rd_word),
        .out_vld  (rd_valid),
        .out_data (rd_data)
    );

endmodule
